disp_share_arbiter: RTL
=======================

// Module: disp_share_arbiter
// PURPOSE
//  Shares the single 8-digit hex display driver among N_REQ requesters (e.g. operand entry,
//  result, error code). Round-robin grants one requester at a time, latches its 32-bit value
//  and keeps it on the display for at least HOLD_CYC clocks before switching owner.
//  Sits between the calculator core and the display driver. Drives the driver's 32-bit value
//  input and its one-shot start/enable input.
// PARAMETERS
//  N_REQ     3           number of requesters, 2..4
//  HOLD_CYC  50_000_000  minimum display time per grant, in clk cycles, >=1
//  CNT_W     26          hold counter width, must satisfy 2**CNT_W > HOLD_CYC
// PORTS
//  clk         in   1         clock
//  rst_n       in   1         reset, asynchronous, active-low
//  clear       in   1         synchronous clear: blank and idle the display
//  req_valid   in   N_REQ     requester i has a value to show
//  req_data    in   32*N_REQ  value of requester i, bits [32i+31:32i]
//  req_ready   out  N_REQ     one-cycle accept pulse to requester i
//  disp_value  out  32        value presented to the display driver
//  disp_start  out  1         display enable (sticky), wired to driver start input
//  disp_owner  out  OWN_W     index of the current owner, OWN_W=$clog2(N_REQ)
//  busy        out  1         high while in HOLD
// BEHAVIOUR
//  - Reset: state=IDLE, disp_value=0, disp_start=0, disp_owner=0, req_ready=0, busy=0,
//    hold counter=0, rr pointer=0. Reset mid-HOLD aborts the hold; no ready pulse is issued.
//  - Handshake: requester holds req_valid=1 and req_data stable until it sees req_ready[i]=1
//    for exactly one cycle. It may drop req_valid before a grant, which withdraws the request.
//  - FSM IDLE: if any req_valid, grant the round-robin winner on the next edge. Latency is 1 clk
//    from valid to the ready pulse and the disp_value update. Otherwise stay in IDLE.
//  - Grant (same edge):
//    - disp_value <= req_data[winner], disp_owner <= winner, req_ready[winner] <= 1.
//    - disp_start <= 1. Stays 1 until reset or clear.
//    - cnt <= HOLD_CYC-1, rr pointer <= winner+1 (wraps to 0 after N_REQ-1), state <= HOLD.
//  - FSM HOLD: busy=1, cnt decrements each clk. While cnt!=0, no grants are made and
//    req_ready stays 0. When cnt==0:
//    - any valid: grant the next winner on that edge. This is back-to-back with no IDLE cycle.
//    - no valid: go to IDLE.
//  - Round-robin: search starts at the rr pointer and ascends with wrap; the first valid wins.
//    The previous owner re-requesting alone is granted again.
//  - disp_value and disp_owner are held in IDLE; the last value stays displayed.
//  - clear (priority over grant, below reset): state <= IDLE, disp_value <= 0,
//    disp_start <= 0, cnt <= 0, req_ready <= 0. disp_owner and rr pointer are kept.
//  - HOLD_CYC=1: cnt loads 0, so the owner can change every cycle.
//  - req_ready is never asserted for more than one bit or for more than one cycle per grant.
//  - Widths: cnt is CNT_W unsigned. No arithmetic on data; it passes through unmodified.
// STRUCTURE
//  - Shared package disp_pkg:
//    - DISP_W=32, DIGITS=8
//    - state typedef {IDLE, HOLD}
//    - function rr_next(ptr, N) for the pointer increment with wrap
//  - Sub-module rr_picker: combinational; inputs valid vector and pointer; outputs winner
//    index and any_valid. The arbiter holds the FSM, hold counter, output registers
//    and data mux.
// TESTING  (HOLD_CYC=4, N_REQ=3 for sim)
//  1. Reset check: assert rst_n=0 mid-HOLD -> all outputs 0 immediately, with no clk edge needed.
//  2. Single request: req_valid=3'b010, data1=32'h1234_ABCD -> next edge: req_ready=3'b010,
//     disp_value=1234_ABCD, owner=1, start=1. busy=1 for 4 clk, then IDLE with the value held.
//  3. Contention: all three valid at once, pointer 0 -> grants in order 0,1,2 spaced exactly
//     4 clk apart, no IDLE gap. Each req_ready is a single pulse.
//  4. Hold enforcement: req0 granted, req2 raised 1 clk later -> req2 waits until cnt==0
//     (4 clk after the grant). disp_value does not change earlier.
//  5. Withdrawal: req1 valid then dropped during HOLD, req2 valid -> req2 granted next;
//     req_ready[1] is never asserted.
//  6. Clear: clear=1 during HOLD with value 0000_00FF -> next edge: disp_value=0, start=0,
//     IDLE. A pending valid is granted only after clear deasserts.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-sharing arbiter.
package disp_pkg;

    localparam int DISP_W = 32;
    localparam int DIGITS = 8;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    // Round-robin pointer advance with wrap back to 0 after n-1.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid at or above the pointer, with wrap.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int OWN_W = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [OWN_W-1:0] i_ptr,
    output logic [OWN_W-1:0] o_winner,
    output logic             o_any
);

    always_comb begin
        int   idx;
        logic found;
        o_winner = '0;
        o_any    = |i_valid;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && i_valid[idx]) begin
                found    = 1'b1;
                o_winner = OWN_W'(idx);
            end
        end
    end

endmodule

// File: rtl/disp_share_arbiter.sv
// Time-shares one 8-digit hex display among N_REQ requesters, round-robin,
// holding each granted value for at least HOLD_CYC clocks.
module disp_share_arbiter
    import disp_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int HOLD_CYC = 50_000_000,
    parameter int CNT_W    = 26,
    localparam int OWN_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [DISP_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DISP_W-1:0]       disp_value,
    output logic                    disp_start,
    output logic [OWN_W-1:0]        disp_owner,
    output logic                    busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant;
    logic               w_any;
    logic [OWN_W-1:0]   w_winner;
    logic [DISP_W-1:0]  w_sel_data;
    logic [OWN_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_ready;
    logic [DISP_W-1:0]  r_value;
    logic               r_start;
    logic [OWN_W-1:0]   r_owner;

    rr_picker #(.N_REQ(N_REQ), .OWN_W(OWN_W)) u_pick (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_sel_data = req_data[w_winner*DISP_W +: DISP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // clear outranks any grant, so a pending request waits until clear drops
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    if (w_any) w_grant     = 1'b1;
                    else       w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear) begin
            w_grant     = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= '0;
            r_value <= '0;
            r_start <= 1'b0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_ready <= '0;
            if (clear) begin
                r_value <= '0;
                r_start <= 1'b0;
                r_cnt   <= '0;
            end else if (w_grant) begin
                r_value <= w_sel_data;
                r_owner <= w_winner;
                r_ready <= N_REQ'(1) << w_winner;
                r_start <= 1'b1;
                r_cnt   <= CNT_W'(HOLD_CYC - 1);
                r_ptr   <= OWN_W'(rr_next(int'(w_winner), N_REQ));
            end else if (r_state == HOLD && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign req_ready  = r_ready;
    assign disp_value = r_value;
    assign disp_start = r_start;
    assign disp_owner = r_owner;
    assign busy       = (r_state == HOLD);

endmodule
